// File: rtl/button_event_arbiter.sv
// Multi-button press-event scheduler: edge-detects debounced buttons, queues one press per
// button and serves them round-robin through a single valid/ready event slot.
module button_event_arbiter #(
  parameter int N             = 4,
  parameter int IDW           = 2,
  parameter bit PRESSED_LEVEL = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   pb_debounced,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [7:0]     drop_count,
  input  logic           clr_drops
);

  localparam logic [N-1:0]   PRESSED_VEC = {N{PRESSED_LEVEL}};
  localparam logic [N-1:0]   LSB_ONLY    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] RR_RESET    = IDW'(N - 1);

  logic [N-1:0]   delay_q;
  logic [N-1:0]   pending_q, pending_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rr_last_q, rr_last_d;
  logic [7:0]     drop_q, drop_d;

  logic [N-1:0]   press;
  logic           slot_free;
  logic           found;
  logic [IDW-1:0] winner;
  logic [N-1:0]   load_mask;
  logic           drop_hit;

  // A press is a transition into the pressed level; releases are ignored.
  assign press     = ~(pb_debounced ^ PRESSED_VEC) & (delay_q ^ PRESSED_VEC);
  assign slot_free = !valid_q || evt_ready;

  // Round-robin search starting just after the last winner; registered pending only.
  always_comb begin
    int          idx;
    logic [N-1:0] rotated;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found     = 1'b0;
    winner    = '0;
    load_mask = '0;
    idx       = 0;
    rotated   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_last_q) + k;
      if (idx >= N) idx = idx - N;
      rotated = pending_q >> idx;
      if (!found && rotated[0]) begin
        found     = 1'b1;
        winner    = IDW'(idx);
        load_mask = LSB_ONLY << idx;
      end
    end
  end

  always_comb begin
    logic load;
    load      = slot_free && found;
    pending_d = (pending_q & ~(load ? load_mask : '0)) | press;
    drop_hit  = |(press & pending_q & ~(load ? load_mask : '0));

    valid_d   = slot_free ? found : valid_q;
    id_d      = load ? winner : id_q;
    rr_last_d = load ? winner : rr_last_q;

    if (clr_drops)                       drop_d = '0;
    else if (drop_hit && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    else                                  drop_d = drop_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the edge detector is loaded, not cleared, so a button held through reset is not a press.
      delay_q   <= pb_debounced;
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      rr_last_q <= RR_RESET;
      drop_q    <= '0;
    end else begin
      delay_q   <= pb_debounced;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
      drop_q    <= drop_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_id     = id_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule
